// File: rtl/ram_word_adapter_if.sv
// Bus bundle for ram_word_adapter: CPU-side 32-bit word port and RAM-side
// 16-bit halfword port.
//   master : environment view (drives CPU requests and RAM responses)
//   slave  : adapter view (answers CPU requests, drives the RAM port)
// When RAM_ADAPTER_ALIGN_CHECK_EN is defined the bundle also carries cpu_err.
interface ram_word_adapter_if;
  localparam int unsigned CPU_ADR_W = 19;
  localparam int unsigned RAM_ADR_W = 18;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned HALF_W    = 16;
  localparam int unsigned BE_W      = 4;
  localparam int unsigned SEL_W     = 2;

  logic [CPU_ADR_W-1:0] cpu_adr;
  logic                 cpu_req;
  logic                 cpu_write;
  logic [BE_W-1:0]      cpu_be;
  logic [DATA_W-1:0]    cpu_wdata;
  logic [DATA_W-1:0]    cpu_rdata;
  logic                 cpu_ack;
  logic                 cpu_busy;
`ifdef RAM_ADAPTER_ALIGN_CHECK_EN
  logic                 cpu_err;
`endif
  logic [RAM_ADR_W-1:0] ram_adr;
  logic                 ram_req;
  logic                 ram_ack;
  logic                 ram_write;
  logic [SEL_W-1:0]     ram_sel;
  logic [HALF_W-1:0]    ram_rdata;
  logic [HALF_W-1:0]    ram_wdata;

  modport master (
    output cpu_adr, cpu_req, cpu_write, cpu_be, cpu_wdata, ram_ack, ram_rdata,
    input  cpu_rdata, cpu_ack, cpu_busy, ram_adr, ram_req, ram_write, ram_sel, ram_wdata
`ifdef RAM_ADAPTER_ALIGN_CHECK_EN
    , input cpu_err
`endif
  );

  modport slave (
    input  cpu_adr, cpu_req, cpu_write, cpu_be, cpu_wdata, ram_ack, ram_rdata,
    output cpu_rdata, cpu_ack, cpu_busy, ram_adr, ram_req, ram_write, ram_sel, ram_wdata
`ifdef RAM_ADAPTER_ALIGN_CHECK_EN
    , output cpu_err
`endif
  );
endinterface

// File: rtl/ram_word_adapter.sv
// ram_word_adapter: splits each 32-bit CPU access into up to two 16-bit RAM
// accesses (LO halfword, then HI halfword).
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - ram_word_adapter_if.slave (CPU word port + RAM halfword port)
// Optional: RAM_ADAPTER_ALIGN_CHECK_EN adds cpu_err and rejects requests with
// cpu_adr[1:0] != 0 without touching the RAM.
module ram_word_adapter (
  input  logic              clk,
  input  logic              rst,
  ram_word_adapter_if.slave bus
);
  localparam int unsigned WORD_W    = 17;
  localparam int unsigned RAM_ADR_W = 18;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned HALF_W    = 16;
  localparam int unsigned SEL_W     = 2;

  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, SETTLE = 2'd3} state_t;

  state_t state, state_next;

  logic                 wr_q, wr_d;
  logic [SEL_W-1:0]     be_hi_q, be_hi_d;
  logic [HALF_W-1:0]    wdata_hi_q, wdata_hi_d;
  logic [WORD_W-1:0]    word_q, word_d;

  logic                 ram_req_q, ram_req_d;
  logic                 ram_write_q, ram_write_d;
  logic [SEL_W-1:0]     ram_sel_q, ram_sel_d;
  logic [RAM_ADR_W-1:0] ram_adr_q, ram_adr_d;
  logic [HALF_W-1:0]    ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic                 cpu_ack_q, cpu_ack_d;
  logic                 cpu_busy_q, cpu_busy_d;

  // Request classification from the live CPU inputs (only meaningful in IDLE)
  logic zero_be, hi_only, misalign, need_hi;
  assign zero_be = bus.cpu_write && (bus.cpu_be == 4'b0000);
  assign hi_only = bus.cpu_write && (bus.cpu_be[1:0] == 2'b00);
  // After LO, reads always continue; writes only if a high byte is enabled
  assign need_hi = !wr_q || (be_hi_q != 2'b00);

`ifdef RAM_ADAPTER_ALIGN_CHECK_EN
  logic cpu_err_q, cpu_err_d;
  assign misalign = (bus.cpu_adr[1:0] != 2'b00);
  assign bus.cpu_err = cpu_err_q;
`else
  logic unused_adr_lsb;
  assign misalign       = 1'b0;
  assign unused_adr_lsb = ^bus.cpu_adr[1:0];
`endif

  // State register plus registered outputs and latched request
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_q        <= 1'b0;
      be_hi_q     <= '0;
      wdata_hi_q  <= '0;
      word_q      <= '0;
      ram_req_q   <= 1'b0;
      ram_write_q <= 1'b0;
      ram_sel_q   <= '0;
      ram_adr_q   <= '0;
      ram_wdata_q <= '0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_busy_q  <= 1'b0;
`ifdef RAM_ADAPTER_ALIGN_CHECK_EN
      cpu_err_q   <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      wr_q        <= wr_d;
      be_hi_q     <= be_hi_d;
      wdata_hi_q  <= wdata_hi_d;
      word_q      <= word_d;
      ram_req_q   <= ram_req_d;
      ram_write_q <= ram_write_d;
      ram_sel_q   <= ram_sel_d;
      ram_adr_q   <= ram_adr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_busy_q  <= cpu_busy_d;
`ifdef RAM_ADAPTER_ALIGN_CHECK_EN
      cpu_err_q   <= cpu_err_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (bus.cpu_req) begin
          if (misalign || zero_be) state_next = SETTLE;
          else if (hi_only)        state_next = HI;
          else                     state_next = LO;
        end
      end
      LO:      if (bus.ram_ack) state_next = need_hi ? HI : SETTLE;
      HI:      if (bus.ram_ack) state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next values; RAM port fields hold unless reloaded
  always_comb begin
    wr_d        = wr_q;
    be_hi_d     = be_hi_q;
    wdata_hi_d  = wdata_hi_q;
    word_d      = word_q;
    ram_req_d   = ram_req_q;
    ram_write_d = ram_write_q;
    ram_sel_d   = ram_sel_q;
    ram_adr_d   = ram_adr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    cpu_busy_d  = (state_next != IDLE);
`ifdef RAM_ADAPTER_ALIGN_CHECK_EN
    cpu_err_d   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (bus.cpu_req) begin
          wr_d       = bus.cpu_write;
          be_hi_d    = bus.cpu_be[3:2];
          wdata_hi_d = bus.cpu_wdata[31:16];
          word_d     = bus.cpu_adr[18:2];
          if (misalign) begin
            cpu_ack_d   = 1'b1;
            cpu_rdata_d = '0;
`ifdef RAM_ADAPTER_ALIGN_CHECK_EN
            cpu_err_d   = 1'b1;
`endif
          end else if (zero_be) begin
            cpu_ack_d = 1'b1;
          end else begin
            ram_req_d   = 1'b1;
            ram_write_d = bus.cpu_write;
            if (hi_only) begin
              ram_adr_d   = {bus.cpu_adr[18:2], 1'b1};
              ram_sel_d   = bus.cpu_be[3:2];
              ram_wdata_d = bus.cpu_wdata[31:16];
            end else begin
              ram_adr_d   = {bus.cpu_adr[18:2], 1'b0};
              ram_sel_d   = bus.cpu_write ? bus.cpu_be[1:0] : 2'b11;
              ram_wdata_d = bus.cpu_wdata[15:0];
            end
          end
        end
      end
      LO: begin
        if (bus.ram_ack) begin
          if (!wr_q) cpu_rdata_d[15:0] = bus.ram_rdata;
          if (need_hi) begin
            // ram_req stays high; retarget to the HI halfword at the same edge
            ram_adr_d   = {word_q, 1'b1};
            ram_sel_d   = wr_q ? be_hi_q : 2'b11;
            ram_wdata_d = wdata_hi_q;
          end else begin
            ram_req_d   = 1'b0;
            ram_write_d = 1'b0;
            cpu_ack_d   = 1'b1;
          end
        end
      end
      HI: begin
        if (bus.ram_ack) begin
          if (!wr_q) cpu_rdata_d[31:16] = bus.ram_rdata;
          ram_req_d   = 1'b0;
          ram_write_d = 1'b0;
          cpu_ack_d   = 1'b1;
        end
      end
      default: ; // SETTLE swallows the controller's trailing duplicate ack
    endcase
  end

  assign bus.ram_req   = ram_req_q;
  assign bus.ram_write = ram_write_q;
  assign bus.ram_sel   = ram_sel_q;
  assign bus.ram_adr   = ram_adr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_busy  = cpu_busy_q;
endmodule

// File: tb/tb_ram_word_adapter.sv
// Bench for ram_word_adapter: directed cases plus randomized traffic against a
// word-level reference memory; the RAM side is a halfword memory model that
// acks an access in the cycle it sees ram_req (fast mode) or after a random
// wait, never in two consecutive cycles.
module tb_ram_word_adapter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [15:0] mem      [0:127];
  logic [31:0] ref_words[0:63];

  ram_word_adapter_if bus ();

  ram_word_adapter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive_ram_noise();
    bus.ram_ack   = 1'($urandom_range(0, 1));
    bus.ram_rdata = 16'($urandom);
  endtask

  // Idle cycles with stray RAM acks that must have no effect
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_eq("idle_busy", 32'(bus.cpu_busy), 32'd0);
      chk_eq("idle_ack", 32'(bus.cpu_ack), 32'd0);
      chk_eq("idle_ram_req", 32'(bus.ram_req), 32'd0);
`ifdef RAM_ADAPTER_ALIGN_CHECK_EN
      chk_eq("idle_err", 32'(bus.cpu_err), 32'd0);
`endif
      drive_ram_noise();
    end
  endtask

  // One CPU transaction; entered at a negedge while the DUT is IDLE or SETTLE,
  // returns at the negedge of the cpu_ack cycle.
  task automatic run_txn(input bit wr, input logic [18:0] adr, input logic [3:0] be,
                         input logic [31:0] wdata, input bit fast, input bit settle_noise);
    logic [17:0] e_adr [2];
    logic [1:0]  e_sel [2];
    logic [15:0] e_wd  [2];
    logic [16:0] w;
    logic [31:0] e_rd;
    logic [31:0] tmp;
    logic [15:0] h;
    int          n_exp, n_acc, cyc, last_ack, idx;
    bit          got, ack_prev, mis;

    w   = adr[18:2];
    mis = 1'b0;
`ifdef RAM_ADAPTER_ALIGN_CHECK_EN
    mis = (adr[1:0] != 2'b00);
`endif
    n_exp = 0;
    if (!mis) begin
      if (!wr) begin
        e_adr[0] = {w, 1'b0}; e_sel[0] = 2'b11; e_wd[0] = 16'h0;
        e_adr[1] = {w, 1'b1}; e_sel[1] = 2'b11; e_wd[1] = 16'h0;
        n_exp = 2;
      end else begin
        if (be[1:0] != 2'b00) begin
          e_adr[n_exp] = {w, 1'b0}; e_sel[n_exp] = be[1:0]; e_wd[n_exp] = wdata[15:0];
          n_exp++;
        end
        if (be[3:2] != 2'b00) begin
          e_adr[n_exp] = {w, 1'b1}; e_sel[n_exp] = be[3:2]; e_wd[n_exp] = wdata[31:16];
          n_exp++;
        end
      end
    end
    e_rd = mis ? 32'h0 : ref_words[w[5:0]];
    if (wr && !mis) begin
      tmp = ref_words[w[5:0]];
      for (int b = 0; b < 4; b++) if (be[b]) tmp[8*b +: 8] = wdata[8*b +: 8];
      ref_words[w[5:0]] = tmp;
    end

    bus.cpu_req   = 1'b1;
    bus.cpu_write = wr;
    bus.cpu_adr   = adr;
    bus.cpu_be    = be;
    bus.cpu_wdata = wdata;
    if (bus.cpu_busy) begin
      // Request presented during SETTLE must wait for IDLE
      @(negedge clk);
      chk_eq("settle_len", 32'(bus.cpu_busy), 32'd0);
      chk_eq("ack_pulse", 32'(bus.cpu_ack), 32'd0);
      drive_ram_noise();
    end
    @(posedge clk);

    n_acc = 0; cyc = 0; last_ack = 0; got = 1'b0; ack_prev = 1'b0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      chk_eq("busy", 32'(bus.cpu_busy), 32'd1);
      if (bus.cpu_ack) begin
        got = 1'b1;
        chk_eq("ack_ram_req", 32'(bus.ram_req), 32'd0);
        chk_eq("ram_access_count", 32'(n_acc), 32'(n_exp));
        chk_eq("ack_after_last_ram_ack", 32'(cyc), 32'(last_ack + 1));
        if (fast) chk_eq("ack_latency", 32'(cyc), (n_exp == 2) ? 32'd4 : (n_exp == 1) ? 32'd2 : 32'd1);
        if (!wr || mis) chk_eq("rdata", bus.cpu_rdata, e_rd);
`ifdef RAM_ADAPTER_ALIGN_CHECK_EN
        chk_eq("err", 32'(bus.cpu_err), 32'(mis));
`endif
        bus.cpu_req   = 1'b0;
        bus.ram_ack   = settle_noise;
        bus.ram_rdata = 16'($urandom);
      end else begin
`ifdef RAM_ADAPTER_ALIGN_CHECK_EN
        chk_eq("err_early", 32'(bus.cpu_err), 32'd0);
`endif
        if (bus.ram_req && !ack_prev && (fast || $urandom_range(0, 3) != 0)) begin
          if (n_acc < n_exp) begin
            chk_eq("ram_adr", 32'(bus.ram_adr), 32'(e_adr[n_acc]));
            chk_eq("ram_sel", 32'(bus.ram_sel), 32'(e_sel[n_acc]));
            chk_eq("ram_write", 32'(bus.ram_write), 32'(wr));
            if (wr) chk_eq("ram_wdata", 32'(bus.ram_wdata), 32'(e_wd[n_acc]));
            idx = int'(bus.ram_adr[6:0]);
            if (bus.ram_write) begin
              h = mem[idx];
              if (bus.ram_sel[0]) h[7:0]  = bus.ram_wdata[7:0];
              if (bus.ram_sel[1]) h[15:8] = bus.ram_wdata[15:8];
              mem[idx] = h;
            end
            bus.ram_rdata = mem[idx];
          end else begin
            chk_eq("extra_ram_access", 32'(n_acc + 1), 32'(n_exp));
            bus.ram_rdata = 16'($urandom);
          end
          bus.ram_ack = 1'b1;
          ack_prev    = 1'b1;
          last_ack    = cyc;
          n_acc++;
        end else begin
          bus.ram_ack = 1'b0;
          ack_prev    = 1'b0;
        end
      end
    end
    chk_eq("ack_timeout", 32'(got), 32'd1);
  endtask

  logic [15:0] saved;
  logic [18:0] radr;
  logic [3:0]  rbe;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_write = 1'b0; bus.cpu_adr = '0;
    bus.cpu_be  = 4'h0; bus.cpu_wdata = '0;
    bus.ram_ack = 1'b0; bus.ram_rdata = '0;
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    mem[8] = 16'hBEEF;
    mem[9] = 16'hDEAD;
    for (int i = 0; i < 64; i++) ref_words[i] = {mem[2*i+1], mem[2*i]};

    // Reset holds everything at zero even with a request and stray acks present
    repeat (3) begin
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_adr = 19'h10;
      drive_ram_noise();
    end
    @(negedge clk);
    chk_eq("rst_ram_req", 32'(bus.ram_req), 32'd0);
    chk_eq("rst_ram_write", 32'(bus.ram_write), 32'd0);
    chk_eq("rst_ram_sel", 32'(bus.ram_sel), 32'd0);
    chk_eq("rst_ram_adr", 32'(bus.ram_adr), 32'd0);
    chk_eq("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
    chk_eq("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    chk_eq("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk_eq("rst_cpu_busy", 32'(bus.cpu_busy), 32'd0);
`ifdef RAM_ADAPTER_ALIGN_CHECK_EN
    chk_eq("rst_cpu_err", 32'(bus.cpu_err), 32'd0);
`endif
    bus.cpu_req = 1'b0;
    rst = 1'b0;
    idle(2);

    // Full read: halfwords 0x8 then 0x9
    run_txn(1'b0, 19'h00010, 4'hF, 32'h0, 1'b1, 1'b0);
    chk_eq("read_deadbeef", bus.cpu_rdata, 32'hDEADBEEF);
    idle(1);

    // High-half-only write lands at halfword 0x11 only
    saved = mem[16];
    run_txn(1'b1, 19'h00020, 4'b1100, 32'h12345678, 1'b1, 1'b0);
    idle(1);
    chk_eq("mem_hi_written", 32'(mem[17]), 32'h1234);
    chk_eq("mem_lo_untouched", 32'(mem[16]), 32'(saved));

    // Zero byte-enable write and low-half-only write
    run_txn(1'b1, 19'h00024, 4'b0000, 32'hFFFFFFFF, 1'b1, 1'b0);
    idle(1);
    run_txn(1'b1, 19'h00028, 4'b0001, 32'hA5A5A5A5, 1'b1, 1'b0);
    idle(1);

    // Back-to-back with a stray ack injected during SETTLE
    run_txn(1'b1, 19'h00030, 4'hF, 32'hCAFEF00D, 1'b1, 1'b1);
    run_txn(1'b0, 19'h00030, 4'h0, 32'h0, 1'b1, 1'b1);
    run_txn(1'b0, 19'h00010, 4'h0, 32'h0, 1'b1, 1'b1);
    idle(2);

    // Reset while in HI aborts the read
    bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_adr = 19'h00040; bus.cpu_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk_eq("abort_lo_adr", 32'(bus.ram_adr), 32'h20);
    bus.ram_ack = 1'b1; bus.ram_rdata = mem[32];
    @(negedge clk);
    chk_eq("abort_hi_adr", 32'(bus.ram_adr), 32'h21);
    bus.ram_ack = 1'b0;
    bus.cpu_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_eq("abort_ram_req", 32'(bus.ram_req), 32'd0);
    chk_eq("abort_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    chk_eq("abort_busy", 32'(bus.cpu_busy), 32'd0);
    chk_eq("abort_rdata", bus.cpu_rdata, 32'd0);
    rst = 1'b0;
    idle(2);
    run_txn(1'b0, 19'h00040, 4'hF, 32'h0, 1'b1, 1'b0);
    idle(1);

`ifdef RAM_ADAPTER_ALIGN_CHECK_EN
    // Misaligned requests are rejected without RAM traffic
    run_txn(1'b0, 19'h00003, 4'hF, 32'h0, 1'b1, 1'b0);
    idle(1);
    run_txn(1'b1, 19'h00042, 4'hF, 32'h11112222, 1'b1, 1'b0);
    idle(1);
`endif

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      radr = {2'b00, 11'($urandom_range(0, 63)), 6'h0} >> 4;
      radr[1:0] = 2'($urandom_range(0, 3));
`ifdef RAM_ADAPTER_ALIGN_CHECK_EN
      if ($urandom_range(0, 7) != 0) radr[1:0] = 2'b00;
`endif
      rbe = 4'($urandom);
      if ($urandom_range(0, 5) == 0) rbe = 4'h0;
      run_txn(1'($urandom_range(0, 1)), radr, rbe, $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) != 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);

    // Read back every word through the adapter
    for (int i = 0; i < 64; i++) begin
      radr = {i[16:0], 2'b00};
      run_txn(1'b0, radr, 4'hF, 32'h0, 1'b0, 1'b1);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_word_adapter.md
RAM_WORD_ADAPTER -- requirements
Module: ram_word_adapter

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 cpu_adr  in  19  byte address; word = cpu_adr[18:2]; bits [1:0] ignored unless REQ-031 applies.
REQ-004 cpu_req  in  1  request level; sampled only in IDLE.
REQ-005 cpu_write  in  1  1 = write, 0 = read; latched on acceptance.
REQ-006 cpu_be  in  4  byte enables, bit n = byte n of cpu_wdata; latched on acceptance.
REQ-007 cpu_wdata  in  32  write data; latched on acceptance.
REQ-008 cpu_rdata  out  32  read data; valid while cpu_ack is high, held until the next read completes.
REQ-009 cpu_ack  out  1  one-cycle completion pulse.
REQ-010 cpu_busy  out  1  high whenever state is not IDLE.
REQ-011 ram_adr  out  18  halfword address to the RAM controller port.
REQ-012 ram_req  out  1  RAM request level.
REQ-013 ram_ack  in  1  RAM controller acceptance pulse; ram_rdata is valid in the same cycle.
REQ-014 ram_write  out  1  RAM write strobe qualifier.
REQ-015 ram_sel  out  2  halfword byte lanes, bit0 = low byte, bit1 = high byte.
REQ-016 ram_rdata  in  16  RAM read data.
REQ-017 ram_wdata  out  16  RAM write data.

Function
REQ-018 The block SHALL split each 32-bit access into at most two 16-bit RAM accesses: LO at {cpu_adr[18:2],1'b0} with cpu_be[1:0] and cpu_wdata[15:0], then HI at {cpu_adr[18:2],1'b1} with cpu_be[3:2] and cpu_wdata[31:16].
REQ-019 The state machine SHALL use the states IDLE, LO, HI and SETTLE.
REQ-020 IDLE: when cpu_req is high, the block SHALL latch all cpu_* inputs and set ram_req=1, then go to LO. For a write with cpu_be[1:0]==0 it SHALL go directly to HI.
REQ-021 A write with cpu_be==0 SHALL make no RAM access: cpu_ack pulses on the cycle after acceptance and the state returns to IDLE via SETTLE.
REQ-022 Reads SHALL always perform both halves with ram_sel=2'b11, ignoring cpu_be.
REQ-023 LO, on ram_ack: a read SHALL capture ram_rdata into cpu_rdata[15:0]. If HI is needed, the block SHALL keep ram_req=1, update ram_adr/ram_sel/ram_wdata for HI at the same edge, and go to HI. Otherwise it completes as in REQ-024.
REQ-024 HI, on ram_ack: a read SHALL capture ram_rdata into cpu_rdata[31:16]. The block SHALL clear ram_req and ram_write, pulse cpu_ack for exactly one cycle, and go to SETTLE.
REQ-025 SETTLE SHALL last exactly one cycle, ignore ram_ack (this absorbs the trailing duplicate access the RAM controller issues while ram_req falls), and then return to IDLE.
REQ-026 ram_ack in IDLE or SETTLE SHALL have no effect.
REQ-027 With a RAM controller that acks one cycle after seeing ram_req, a full read or write SHALL give cpu_ack in the 4th cycle after the acceptance edge. A single-half write SHALL give it in the 2nd cycle.
REQ-028 ram_req SHALL stay high continuously from LO entry until the HI ack (no deassertion between halves). The requester SHALL drop cpu_req after cpu_ack.

Reset
REQ-029 While rst is high: state=IDLE, ram_req=0, ram_write=0, ram_sel=0, ram_adr=0, ram_wdata=0, cpu_ack=0, cpu_rdata=0, cpu_busy=0.
REQ-030 Reset asserted mid-transaction SHALL abort it: no cpu_ack is generated, and the partial RAM write is not undone.

Configuration
REQ-031 With macro RAM_ADAPTER_ALIGN_CHECK_EN defined, the block SHALL add output port cpu_err (1 bit, reset 0). A request with cpu_adr[1:0]!=0 SHALL make no RAM access and SHALL pulse cpu_ack and cpu_err together on the cycle after acceptance, with cpu_rdata=0. Without the macro, cpu_err SHALL be absent and cpu_adr[1:0] SHALL be ignored.

Verification
REQ-032 Read: cpu_adr=0x00010, RAM halfword 0x8=0xBEEF, halfword 0x9=0xDEAD -> ram_adr sequence 0x8 then 0x9, cpu_rdata=0xDEADBEEF, cpu_ack 4 cycles after acceptance.
REQ-033 Write with cpu_be=4'b1100, cpu_wdata=0x12345678, cpu_adr=0x00020 -> exactly one RAM write at ram_adr 0x11 with ram_sel=2'b11 and ram_wdata=0x1234; cpu_ack 2 cycles after acceptance.
REQ-034 Write with cpu_be=4'b0000 -> ram_req never asserted; cpu_ack on the cycle after acceptance.
REQ-035 Back-to-back: a second cpu_req presented right after the first cpu_ack, plus an injected extra ram_ack during SETTLE -> the second transaction's LO data is not corrupted.
REQ-036 rst pulsed while in HI -> the next cycle shows state IDLE, ram_req=0 and cpu_ack=0; the next request completes normally.
REQ-037 With RAM_ADAPTER_ALIGN_CHECK_EN defined, cpu_adr=0x00003 -> cpu_err=1 and cpu_ack=1 in the same cycle, and no ram_req.
